// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Optional macro MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] CNT_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] CNT_DIV  = 4'(DIV_CYCLES);

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [3:0]  op_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;

  logic        is_mul;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [63:0] res;
  logic        res_we;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
             (MADD_EN && (op >= OP_MADD) && (op <= OP_MSUBU));
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Products are computed on the latched operands; the low 64 bits of a
  // sign-extended 64x64 product equal the signed 32x32 product.
  always_comb begin
    prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    prod_u = {32'd0, a_reg} * {32'd0, b_reg};
  end

  // Signed division via magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_mag = a_reg[31] ? (32'd0 - a_reg) : a_reg;
    b_mag = b_reg[31] ? (32'd0 - b_reg) : b_reg;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_reg != 32'd0) begin
      if (op_reg == OP_DIV) begin
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
      end else begin
        q_mag = a_reg / b_reg;
        r_mag = a_reg % b_reg;
      end
    end
    q_s = (a_reg[31] ^ b_reg[31]) ? (32'd0 - q_mag) : q_mag;
    r_s = a_reg[31] ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    res    = {hi, lo};
    res_we = 1'b0;
    case (op_reg)
      OP_MULT:  begin res = prod_s; res_we = 1'b1; end
      OP_MULTU: begin res = prod_u; res_we = 1'b1; end
      OP_DIV: begin
        res    = {r_s, q_s};
        res_we = (b_reg != 32'd0);
      end
      OP_DIVU: begin
        res    = {r_mag, q_mag};
        res_we = (b_reg != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res = {hi, lo} + prod_s; res_we = 1'b1; end
      OP_MADDU: begin res = {hi, lo} + prod_u; res_we = 1'b1; end
      OP_MSUB:  begin res = {hi, lo} - prod_s; res_we = 1'b1; end
      OP_MSUBU: begin res = {hi, lo} - prod_u; res_we = 1'b1; end
`endif
      default: begin res = {hi, lo}; res_we = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      cnt_reg   <= 4'd0;
      op_reg    <= 4'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              a_reg     <= A;
              b_reg     <= B;
              op_reg    <= op;
              cnt_reg   <= is_div ? CNT_DIV : CNT_MULT;
              state_reg <= RUN;
              busy      <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi <= A;
            end else if (op == OP_MTLO) begin
              lo <= A;
            end
          end
        end
        RUN: begin
          // Result lands on the edge ending the last busy cycle.
          if (cnt_reg == 4'd1) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            cnt_reg   <= 4'd0;
            if (res_we) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
